// File: rtl/uvmt_obi_st_rst_sequencer_if.sv
// ---------------------------------------------------------------------------
// uvmt_obi_st_rst_sequencer_if
// Bundles the soft-reset handshake and the staged reset outputs of the
// self-test reset sequencer.
//
//   soft_rst_req  requester -> sequencer   4-phase soft-reset request
//   soft_rst_ack  sequencer -> requester   soft-reset acknowledge
//   rst_n_out     sequencer -> domains     per-domain active-low resets
//   stage_o       sequencer -> observers   number of domains released
//   rst_done      sequencer -> observers   all domains released
//
// Modports: master = the sequencer, slave = requester / reset consumers.
// NUM_RST must match the NUM_RST of the sequencer the interface is bound to.
// ---------------------------------------------------------------------------
interface uvmt_obi_st_rst_sequencer_if #(
    parameter int NUM_RST = 3
) ();

    localparam int STAGE_W = $clog2(NUM_RST + 1);

    logic                 soft_rst_req;
    logic                 soft_rst_ack;
    logic [NUM_RST-1:0]   rst_n_out;
    logic [STAGE_W-1:0]   stage_o;
    logic                 rst_done;

    modport master (
        input  soft_rst_req,
        output soft_rst_ack,
        output rst_n_out,
        output stage_o,
        output rst_done
    );

    modport slave (
        output soft_rst_req,
        input  soft_rst_ack,
        input  rst_n_out,
        input  stage_o,
        input  rst_done
    );

endinterface

// File: rtl/uvmt_obi_st_rst_sequencer.sv
// ---------------------------------------------------------------------------
// uvmt_obi_st_rst_sequencer
// Turns the bench's global reset into staged, ordered per-domain active-low
// resets. All domains stay low for MIN_HOLD cycles after the sequence starts,
// then domain 0..NUM_RST-1 release one every STAGE_GAP cycles. A 4-phase
// soft-reset handshake re-runs the sequence without the global reset.
//
// Ports
//   clk      in   bench clock, all state updates on posedge
//   reset_n  in   synchronous active-low reset, overrides everything
//   rst_if   master modport of uvmt_obi_st_rst_sequencer_if:
//            soft_rst_req (in), soft_rst_ack, rst_n_out, stage_o, rst_done (out)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module uvmt_obi_st_rst_sequencer #(
    parameter int NUM_RST   = 3,
    parameter int MIN_HOLD  = 16,
    parameter int STAGE_GAP = 4,
    parameter int CNT_W     = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    uvmt_obi_st_rst_sequencer_if.master         rst_if
);

    localparam int STAGE_W = $clog2(NUM_RST + 1);
    localparam int MAX_CMP = (MIN_HOLD > STAGE_GAP) ? MIN_HOLD : STAGE_GAP;

    // The counter is compared against MIN_HOLD-1 / STAGE_GAP-1 and must be
    // able to hold both without wrapping.
    generate
        if ((2 ** CNT_W) <= MAX_CMP) begin : g_cnt_w_too_small
            $error("CNT_W too small for MIN_HOLD/STAGE_GAP");
        end
        if (NUM_RST < 1 || MIN_HOLD < 1 || STAGE_GAP < 1) begin : g_bad_param
            $error("NUM_RST, MIN_HOLD and STAGE_GAP must all be >= 1");
        end
    endgenerate

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_RST - 1);

    // Counter increment that holds at its compare value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_RST-1:0] rst_n_q;
    logic [STAGE_W-1:0] stage_q;
    logic               done_q;
    logic               ack_q;
    logic               pending;   // soft restart in flight, ack owed on DONE
    logic               restart;   // first HOLD cycle after a soft request:
                                   // drop all outputs before timing restarts

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            rst_n_q <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            pending <= 1'b0;
            restart <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (restart) begin
                        rst_n_q <= '0;
                        stage_q <= '0;
                        done_q  <= 1'b0;
                        cnt     <= '0;
                        restart <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        rst_n_q <= NUM_RST'(1);
                        stage_q <= STAGE_W'(1);
                        cnt     <= '0;
                        if (NUM_RST == 1) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                            if (pending) begin
                                ack_q   <= 1'b1;
                                pending <= 1'b0;
                            end
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= sat_inc(cnt, HOLD_LAST);
                    end
                end

                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        // Outputs form a thermometer code, so releasing the
                        // next domain is a shift-in of a one.
                        rst_n_q <= (rst_n_q << 1) | NUM_RST'(1);
                        stage_q <= stage_q + STAGE_W'(1);
                        cnt     <= '0;
                        if (stage_q == LAST_STAGE) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                            if (pending) begin
                                ack_q   <= 1'b1;
                                pending <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= sat_inc(cnt, GAP_LAST);
                    end
                end

                ST_DONE: begin
                    // While ack is high only the req falling level matters;
                    // a still-high req cannot retrigger the sequence.
                    if (ack_q) begin
                        if (!rst_if.soft_rst_req) begin
                            ack_q <= 1'b0;
                        end
                    end else if (rst_if.soft_rst_req) begin
                        pending <= 1'b1;
                        restart <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end

                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    assign rst_if.rst_n_out    = rst_n_q;
    assign rst_if.stage_o      = stage_q;
    assign rst_if.rst_done     = done_q;
    assign rst_if.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_uvmt_obi_st_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uvmt_obi_st_rst_sequencer
// Two sequencer instances share clock and reset: a default one (3 domains,
// hold 16, gap 4) and a minimal one (1 domain, hold 1). Expected output
// snapshots are queued with the posedge count at which they must hold and
// are compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_uvmt_obi_st_rst_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uvmt_obi_st_rst_sequencer_if #(.NUM_RST(3)) rst_if_a ();
    uvmt_obi_st_rst_sequencer_if #(.NUM_RST(1)) rst_if_b ();

    uvmt_obi_st_rst_sequencer #(
        .NUM_RST(3), .MIN_HOLD(16), .STAGE_GAP(4), .CNT_W(8)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_if  (rst_if_a)
    );

    uvmt_obi_st_rst_sequencer #(
        .NUM_RST(1), .MIN_HOLD(1), .STAGE_GAP(4), .CNT_W(8)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .rst_if  (rst_if_b)
    );

    // Snapshot: {rst_n_out[2:0], stage_o[1:0], rst_done, soft_rst_ack}
    logic [6:0] obs_a;
    logic [6:0] obs_b;
    assign obs_a = {rst_if_a.rst_n_out, rst_if_a.stage_o, rst_if_a.rst_done, rst_if_a.soft_rst_ack};
    assign obs_b = {3'b000, rst_if_b.rst_n_out, rst_if_b.stage_o, rst_if_b.rst_done, rst_if_b.soft_rst_ack};

    typedef struct {
        int         cyc;
        int         dut;
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int dut, input int c, input string tag,
                        input logic [2:0] r, input logic [1:0] s,
                        input logic d, input logic a);
        exp_t e;
        e.cyc = c;
        e.dut = dut;
        e.tag = tag;
        e.val = (dut == 0) ? {r, s, d, a} : {3'b000, r[0], s[0], d, a};
        exp_q.push_back(e);
    endtask

    // Default-instance release schedule, cycle k of the sequence at edge b+k.
    task automatic push_timeline(input int b, input logic final_ack);
        push(0, b + 15, "hold_c15",  3'b000, 2'd0, 1'b0, 1'b0);
        push(0, b + 16, "dom0_c16",  3'b001, 2'd1, 1'b0, 1'b0);
        push(0, b + 19, "dom0_c19",  3'b001, 2'd1, 1'b0, 1'b0);
        push(0, b + 20, "dom1_c20",  3'b011, 2'd2, 1'b0, 1'b0);
        push(0, b + 23, "dom1_c23",  3'b011, 2'd2, 1'b0, 1'b0);
        push(0, b + 24, "dom2_c24",  3'b111, 2'd3, 1'b1, final_ack);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called on a falling edge. Drops expectations the reset makes void,
    // asserts reset_n for n edges, then releases it; b = edge before cycle 1.
    task automatic apply_reset(input int n, output int b);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc > cyc) exp_q.delete(i);
        end
        reset_n = 1'b0;
        push(0, cyc + 1, "rst_a", 3'b000, 2'd0, 1'b0, 1'b0);
        push(1, cyc + 1, "rst_b", 3'b000, 2'd0, 1'b0, 1'b0);
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
        b = cyc;
        push_timeline(b, 1'b0);
        push(1, b + 1, "min_first_edge", 3'b001, 2'd1, 1'b1, 1'b0);
    endtask

    // Scoreboard drain: compare every expectation due at this edge count.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    chk(exp_q[i].tag, (exp_q[i].dut == 0) ? obs_a : obs_b, exp_q[i].val);
                    exp_q.delete(i);
                end else if (exp_q[i].cyc < cyc) begin
                    chk({exp_q[i].tag, "_missed"}, 7'bxxxxxxx, exp_q[i].val);
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin
        int b;
        int t;
        rst_if_a.soft_rst_req = 1'b0;
        rst_if_b.soft_rst_req = 1'b0;
        @(negedge clk);

        // Power-on sequence
        apply_reset(5, b);
        wait_to(b + 26);

        // Soft restart from DONE with full handshake
        t = cyc + 1;
        rst_if_a.soft_rst_req = 1'b1;
        push(0, t,      "t3_req_edge", 3'b111, 2'd3, 1'b1, 1'b0);
        push(0, t + 1,  "t3_low",      3'b000, 2'd0, 1'b0, 1'b0);
        push_timeline(t + 1, 1'b1);
        push(0, t + 28, "t3_ack_hold", 3'b111, 2'd3, 1'b1, 1'b1);
        push(0, t + 29, "t3_ack_hold2",3'b111, 2'd3, 1'b1, 1'b1);
        push(0, t + 30, "t3_ack_drop", 3'b111, 2'd3, 1'b1, 1'b0);
        push(0, t + 33, "t3_idle",     3'b111, 2'd3, 1'b1, 1'b0);
        wait_to(t + 29);
        rst_if_a.soft_rst_req = 1'b0;
        wait_to(t + 34);

        // Global reset while ack is high, req kept high across it
        t = cyc + 1;
        rst_if_a.soft_rst_req = 1'b1;
        push(0, t + 25, "t6_ack_up", 3'b111, 2'd3, 1'b1, 1'b1);
        wait_to(t + 26);
        apply_reset(2, b);
        t = b + 25;
        push(0, t,     "t6_req_edge", 3'b111, 2'd3, 1'b1, 1'b0);
        push(0, t + 1, "t6_low",      3'b000, 2'd0, 1'b0, 1'b0);
        push_timeline(t + 1, 1'b1);
        wait_to(t + 26);
        rst_if_a.soft_rst_req = 1'b0;
        push(0, t + 27, "t6_ack_drop", 3'b111, 2'd3, 1'b1, 1'b0);
        wait_to(t + 29);

        // Reset mid-sequence after domain 0 is out
        apply_reset(3, b);
        push(0, b + 17, "t2_dom0_held", 3'b001, 2'd1, 1'b0, 1'b0);
        wait_to(b + 17);
        apply_reset(2, b);
        wait_to(b + 26);

        // Request pulse inside RELEASE is ignored
        apply_reset(2, b);
        wait_to(b + 17);
        rst_if_a.soft_rst_req = 1'b1;
        wait_to(b + 19);
        rst_if_a.soft_rst_req = 1'b0;
        push(0, b + 27, "t4_no_restart", 3'b111, 2'd3, 1'b1, 1'b0);
        push(0, b + 31, "t4_no_ack",     3'b111, 2'd3, 1'b1, 1'b0);
        wait_to(b + 32);

        // Request held high from RELEASE into DONE restarts
        apply_reset(2, b);
        wait_to(b + 20);
        rst_if_a.soft_rst_req = 1'b1;
        t = b + 25;
        push(0, t,     "t4_req_edge", 3'b111, 2'd3, 1'b1, 1'b0);
        push(0, t + 1, "t4_low",      3'b000, 2'd0, 1'b0, 1'b0);
        push_timeline(t + 1, 1'b1);
        wait_to(t + 27);
        rst_if_a.soft_rst_req = 1'b0;
        push(0, t + 28, "t4_ack_drop", 3'b111, 2'd3, 1'b1, 1'b0);
        wait_to(t + 30);

        @(negedge clk);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            chk({exp_q[i].tag, "_unreached"}, 7'bxxxxxxx, exp_q[i].val);
            exp_q.delete(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
